// File: rtl/crc_frame_engine.sv
// Parametrised CRC generator/checker consuming DATA_W bits per accepted beat,
// with first/last framing, registered final CRC, done strobe and residue match.
module crc_frame_engine #(
  parameter int unsigned CRC_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'h00000000,
  parameter int unsigned DATA_W      = 8,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0,
  parameter logic [31:0] RESIDUE     = 32'h00000000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              data_valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic [CRC_W-1:0]  crc_state_out,
  output logic [CRC_W-1:0]  crc_out,
  output logic              done_out,
  output logic              match_out,
  output logic              busy_out
);

  // state  | meaning
  // S_IDLE | between frames; beats without first_in accumulate (headerless mode)
  // S_RUN  | first beat accepted, waiting for the last beat

  localparam logic [CRC_W-1:0] P_POLY    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_INIT    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_XOR     = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_RESIDUE = RESIDUE[CRC_W-1:0];

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   r_crc_out;
  logic               r_done;
  logic               r_match;
  logic [CRC_W-1:0]   w_start;
  logic [CRC_W-1:0]   w_crc_nxt;
  logic [CRC_W-1:0]   w_final;
  logic               w_end;

  // DATA_W serial LFSR steps flattened into one combinational cone
  function automatic logic [CRC_W-1:0] f_step(input logic [CRC_W-1:0] r,
                                              input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] v;
    logic             fb;
    v = r;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fb = (REFLECT_IN ? d[i] : d[int'(DATA_W) - 1 - i]) ^ v[CRC_W-1];
      v  = {v[CRC_W-2:0], 1'b0} ^ (fb ? P_POLY : '0);
    end
    return v;
  endfunction

  function automatic logic [CRC_W-1:0] f_rev(input logic [CRC_W-1:0] r);
    logic [CRC_W-1:0] o;
    for (int i = 0; i < int'(CRC_W); i++) begin
      o[i] = r[int'(CRC_W) - 1 - i];
    end
    return o;
  endfunction

  assign w_start   = first_in ? P_INIT : r_crc;
  assign w_crc_nxt = f_step(w_start, data_in);
  assign w_final   = (REFLECT_OUT ? f_rev(w_crc_nxt) : w_crc_nxt) ^ P_XOR;
  assign w_end     = data_valid_in & last_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (data_valid_in) begin
      if (last_in) begin
        w_state_nxt = S_IDLE;
      end else if (first_in) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  always_comb begin
    busy_out = (r_state == S_RUN);
  end

  // Register reloads INIT on completion so a first beat may follow with no bubble
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_crc     <= P_INIT;
      r_crc_out <= '0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_done <= w_end;
      if (w_end) begin
        r_crc     <= P_INIT;
        r_crc_out <= w_final;
        r_match   <= (w_crc_nxt == P_RESIDUE);
      end else if (data_valid_in) begin
        r_crc <= w_crc_nxt;
      end
    end
  end

  assign crc_state_out = r_crc;
  assign crc_out       = r_crc_out;
  assign done_out      = r_done;
  assign match_out     = r_match;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Self-checking bench: queue-based frame model for the default instance,
// plus literal check values for the reflected, 16-bit and bit-serial variants.
module tb_crc_frame_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld, fst, lst;
  logic [7:0]  dat;
  logic        s_vld, s_fst, s_lst;
  logic [0:0]  s_dat;

  logic [31:0] a_state, a_crc, r_state, r_crc, s_state, s_crc;
  logic        a_done, a_match, a_busy;
  logic        r_done, r_match, r_busy;
  logic [15:0] c_state, c_crc;
  logic        c_done, c_match, c_busy;
  logic        s_done, s_match, s_busy;

  crc_frame_engine u_a (
    .clk_in(clk), .rst_in(rst), .data_valid_in(vld), .data_in(dat),
    .first_in(fst), .last_in(lst), .crc_state_out(a_state), .crc_out(a_crc),
    .done_out(a_done), .match_out(a_match), .busy_out(a_busy));

  crc_frame_engine #(.XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_r (
    .clk_in(clk), .rst_in(rst), .data_valid_in(vld), .data_in(dat),
    .first_in(fst), .last_in(lst), .crc_state_out(r_state), .crc_out(r_crc),
    .done_out(r_done), .match_out(r_match), .busy_out(r_busy));

  crc_frame_engine #(.CRC_W(16), .POLY(32'h00001021), .INIT(32'h0000FFFF)) u_c (
    .clk_in(clk), .rst_in(rst), .data_valid_in(vld), .data_in(dat),
    .first_in(fst), .last_in(lst), .crc_state_out(c_state), .crc_out(c_crc),
    .done_out(c_done), .match_out(c_match), .busy_out(c_busy));

  crc_frame_engine #(.DATA_W(1)) u_s (
    .clk_in(clk), .rst_in(rst), .data_valid_in(s_vld), .data_in(s_dat),
    .first_in(s_fst), .last_in(s_lst), .crc_state_out(s_state), .crc_out(s_crc),
    .done_out(s_done), .match_out(s_match), .busy_out(s_busy));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Textbook MSB-first CRC-32/MPEG-2 over a whole byte sequence
  function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      c = c ^ {q[k], 24'h0};
      for (int b = 0; b < 8; b++) begin
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
    end
    return c;
  endfunction

  // Model: bytes since the last frame boundary; register == CRC of them
  logic [7:0]  m_q[$];
  logic [31:0] m_crc = '0;
  logic        m_run = 1'b0, m_done = 1'b0, m_match = 1'b0;
  bit          chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_run = 1'b0; m_done = 1'b0; m_crc = '0; m_match = 1'b0;
    end else begin
      m_done = 1'b0;
      if (vld) begin
        if (fst) m_q.delete();
        m_q.push_back(dat);
        if (lst) begin
          m_crc   = crc_of(m_q);
          m_match = (m_crc == 32'h0);
          m_done  = 1'b1;
          m_run   = 1'b0;
          m_q.delete();
        end else if (fst) begin
          m_run = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("state", a_state, crc_of(m_q));
      chk("busy", 32'(a_busy), 32'(m_run));
      chk("done", 32'(a_done), 32'(m_done));
      chk("crc_out", a_crc, m_crc);
      chk("match", 32'(a_match), 32'(m_match));
    end
  end

  task automatic frame(input logic [7:0] b[$], input bit with_first, input bit with_last);
    foreach (b[k]) begin
      vld = 1'b1;
      dat = b[k];
      fst = with_first && (k == 0);
      lst = with_last && (k == b.size() - 1);
      @(posedge clk); #1;
    end
    vld = 1'b0; fst = 1'b0; lst = 1'b0;
  endtask

  logic [7:0] msg[$];
  logic [7:0] q2[$];
  logic [7:0] abc[$];
  logic [7:0] one[$];
  string      txt;

  initial begin
    rst = 1'b1; vld = 1'b0; fst = 1'b0; lst = 1'b0; dat = '0;
    s_vld = 1'b0; s_fst = 1'b0; s_lst = 1'b0; s_dat = '0;
    txt = "123456789";
    for (int i = 0; i < txt.len(); i++) msg.push_back(txt[i]);
    abc.push_back(8'h61); abc.push_back(8'h62); abc.push_back(8'h63);

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state", a_state, 32'hFFFFFFFF);
    chk("rst_crc_out", a_crc, 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_state16", {16'h0, c_state}, 32'h0000FFFF);
    chk("model_pin", crc_of(msg), 32'h0376E6E7);

    frame(msg, 1'b1, 1'b1);
    chk("t1_done", 32'(a_done), 32'h1);
    chk("t1_crc", a_crc, 32'h0376E6E7);
    chk("t1_match", 32'(a_match), 32'h0);
    chk("t1_reload", a_state, 32'hFFFFFFFF);
    chk("t3_crc32", r_crc, 32'hCBF43926);
    chk("t4_crc16", {16'h0, c_crc}, 32'h000029B1);

    q2 = msg;
    q2.push_back(8'h03); q2.push_back(8'h76); q2.push_back(8'hE6); q2.push_back(8'hE7);
    frame(q2, 1'b1, 1'b1);
    chk("t2_match", 32'(a_match), 32'h1);
    chk("t2_crc", a_crc, 32'h0);

    for (int i = 0; i < 72; i++) begin
      s_vld = 1'b1;
      s_dat = msg[i / 8][7 - (i % 8)];
      s_fst = (i == 0);
      s_lst = (i == 71);
      @(posedge clk); #1;
    end
    s_vld = 1'b0; s_fst = 1'b0; s_lst = 1'b0;
    chk("t4_serial_done", 32'(s_done), 32'h1);
    chk("t4_serial_crc", s_crc, 32'h0376E6E7);

    for (int k = 0; k < 3; k++) begin
      one.delete();
      one.push_back(8'($urandom_range(0, 255)));
      frame(one, 1'b1, 1'b1);
      chk("t5_single_done", 32'(a_done), 32'h1);
      chk("t5_single_crc", a_crc, crc_of(one));
    end

    foreach (msg[k]) begin
      vld = 1'b1; dat = msg[k]; fst = (k == 0); lst = (k == 8);
      @(posedge clk); #1;
      vld = 1'b0; fst = 1'($urandom); lst = 1'($urandom); dat = 8'($urandom);
      if (k != 8) begin
        repeat (2) begin
          @(posedge clk); #1;
          chk("t5_gap_done", 32'(a_done), 32'h0);
          chk("t5_gap_busy", 32'(a_busy), 32'h1);
        end
      end
    end
    fst = 1'b0; lst = 1'b0;
    chk("t5_gap_crc", a_crc, 32'h0376E6E7);

    frame(abc, 1'b1, 1'b0);
    chk("t5_restart_busy", 32'(a_busy), 32'h1);
    frame(msg, 1'b1, 1'b1);
    chk("t5_restart_crc", a_crc, 32'h0376E6E7);

    for (int k = 0; k < 4; k++) begin
      vld = 1'b1; dat = msg[k]; fst = (k == 0); lst = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1; dat = msg[4]; fst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; vld = 1'b0;
    chk("t6_done", 32'(a_done), 32'h0);
    chk("t6_state", a_state, 32'hFFFFFFFF);
    chk("t6_busy", 32'(a_busy), 32'h0);
    frame(msg, 1'b1, 1'b1);
    chk("t6_crc", a_crc, 32'h0376E6E7);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      vld = ($urandom_range(0, 9) < 7);
      fst = ($urandom_range(0, 99) < 15);
      lst = ($urandom_range(0, 99) < 15);
      dat = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; vld = 1'b0; fst = 1'b0; lst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
